// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_ctrl
// Description : Multi-cycle sequencer for the MIPS datapath. Steps each
//               instruction through FETCH/DECODE/EXEC/MEM/WB over a single
//               shared instruction/data memory port, with a per-access
//               mem_ready timeout that halts the core and flags bus_err.
//               Optional performance counters are enabled by defining the
//               macro MC_PERF_CNT_EN (adds cycle_cnt and instret outputs).
// Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_W           = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  control_type,
    input  logic        writeenable,
    input  logic        mem_read,
    input  logic        word_we,
    input  logic        byte_we,
    input  logic        except,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_addr_sel,
    output logic        mem_wr,
    output logic        ir_we,
    output logic        mdr_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        rf_we,
    output logic        halted,
    output logic        bus_err,
    output logic [2:0]  state_dbg
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret
`endif
);

    localparam logic [2:0]      c_FETCH    = 3'd0;
    localparam logic [2:0]      c_DECODE   = 3'd1;
    localparam logic [2:0]      c_EXEC     = 3'd2;
    localparam logic [2:0]      c_MEM      = 3'd3;
    localparam logic [2:0]      c_WB       = 3'd4;
    localparam logic [2:0]      c_HALT     = 3'd5;
    localparam logic [TO_W-1:0] c_TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
    localparam bit              c_TO_EN    = (TIMEOUT_CYCLES != 0);

    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic [TO_W-1:0] r_to_cnt;
    logic [TO_W-1:0] w_to_inc;
    logic            w_to_last;
    logic            w_to_fire;
    logic            w_store;
    logic            w_mem_op;
    logic            w_enter_acc;
    logic            r_bus_err;

    assign w_store     = word_we | byte_we;
    assign w_mem_op    = mem_read | w_store;
    assign w_to_inc    = r_to_cnt + 1'b1;
    // Current waiting cycle is the last one the memory is allowed
    assign w_to_last   = c_TO_EN && (w_to_inc == c_TO_LIMIT);
    assign w_enter_acc = (w_next != r_state) && ((w_next == c_FETCH) || (w_next == c_MEM));
    assign state_dbg   = r_state;
    assign bus_err     = r_bus_err;

    // State register with asynchronous reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and strobe decode; all outputs forced low while reset is held
    always_comb begin
        w_next       = r_state;
        w_to_fire    = 1'b0;
        mem_req      = 1'b0;
        mem_addr_sel = 1'b0;
        mem_wr       = 1'b0;
        ir_we        = 1'b0;
        mdr_we       = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 2'd0;
        rf_we        = 1'b0;
        halted       = 1'b0;
        case (r_state)
            c_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    w_next = c_DECODE;
                end else if (w_to_last) begin
                    w_to_fire = 1'b1;
                    w_next    = c_HALT;
                end
            end
            c_DECODE: begin
                w_next = except ? c_HALT : c_EXEC;
            end
            c_EXEC: begin
                if (control_type != 2'd0) begin
                    pc_we  = 1'b1;
                    pc_sel = control_type;
                    w_next = c_FETCH;
                end else if (w_mem_op) begin
                    w_next = c_MEM;
                end else if (writeenable) begin
                    w_next = c_WB;
                end else begin
                    w_next = c_FETCH;
                end
            end
            c_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_wr       = w_store;
                if (mem_ready) begin
                    if (w_store) begin
                        w_next = c_FETCH;
                    end else begin
                        mdr_we = 1'b1;
                        w_next = c_WB;
                    end
                end else if (w_to_last) begin
                    w_to_fire = 1'b1;
                    w_next    = c_HALT;
                end
            end
            c_WB: begin
                rf_we  = writeenable;
                w_next = c_FETCH;
            end
            c_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_next = c_FETCH;
            end
        endcase
        if (reset) begin
            mem_req      = 1'b0;
            mem_addr_sel = 1'b0;
            mem_wr       = 1'b0;
            ir_we        = 1'b0;
            mdr_we       = 1'b0;
            pc_we        = 1'b0;
            pc_sel       = 2'd0;
            rf_we        = 1'b0;
            halted       = 1'b0;
        end
    end

    // Per-access wait counter: cleared on entering an access state, counts stalled cycles
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if (w_enter_acc) begin
            r_to_cnt <= '0;
        end else if (mem_req && !mem_ready) begin
            r_to_cnt <= w_to_inc;
        end
    end

    // Sticky bus error, set only by a memory timeout
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bus_err <= 1'b0;
        end else if (w_to_fire) begin
            r_bus_err <= 1'b1;
        end
    end

`ifdef MC_PERF_CNT_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instret;
    logic        w_retire;

    // An instruction retires when the sequencer returns to FETCH from EXEC/MEM/WB
    assign w_retire  = (w_next == c_FETCH) &&
                       ((r_state == c_EXEC) || (r_state == c_MEM) || (r_state == c_WB));
    assign cycle_cnt = r_cycle_cnt;
    assign instret   = r_instret;

    // Free-running cycle and retired-instruction counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cycle_cnt <= '0;
            r_instret   <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_retire) begin
                r_instret <= r_instret + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_multicycle_ctrl
// Description : Self-checking bench for mips_multicycle_ctrl. Each scenario
//               queues per-cycle stimulus rows; expected output vectors are
//               pushed to a scoreboard as each row is driven and popped for
//               comparison once the DUT outputs have settled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_ctrl;

    logic        clock;
    logic        reset;
    logic [1:0]  control_type;
    logic        writeenable;
    logic        mem_read;
    logic        word_we;
    logic        byte_we;
    logic        except;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_addr_sel;
    logic        mem_wr;
    logic        ir_we;
    logic        mdr_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        rf_we;
    logic        halted;
    logic        bus_err;
    logic [2:0]  state_dbg;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret;
`endif

    mips_multicycle_ctrl #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
        .clock        (clock),
        .reset        (reset),
        .control_type (control_type),
        .writeenable  (writeenable),
        .mem_read     (mem_read),
        .word_we      (word_we),
        .byte_we      (byte_we),
        .except       (except),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_addr_sel (mem_addr_sel),
        .mem_wr       (mem_wr),
        .ir_we        (ir_we),
        .mdr_we       (mdr_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .rf_we        (rf_we),
        .halted       (halted),
        .bus_err      (bus_err),
        .state_dbg    (state_dbg)
`ifdef MC_PERF_CNT_EN
        ,
        .cycle_cnt    (cycle_cnt),
        .instret      (instret)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  ct;
        logic        we;
        logic        mr;
        logic        ww;
        logic        bw;
        logic        ex;
        logic        rdy;
        logic [13:0] exp;
    } row_t;

    row_t        rows[$];
    logic [13:0] sb_q[$];
    int          errors = 0;
    int          checks = 0;

    // staged decoder outputs, applied at the start of each row
    logic [1:0] s_ct;
    logic       s_we, s_mr, s_ww, s_bw, s_ex;

    function automatic logic [13:0] ev(input int st, input logic req, input logic asel,
                                       input logic wr, input logic ir, input logic mdr,
                                       input logic pc, input logic [1:0] ps, input logic rf,
                                       input logic h, input logic be);
        return {3'(st), req, asel, wr, ir, mdr, pc, ps, rf, h, be};
    endfunction

    function automatic logic [13:0] obs();
        return {state_dbg, mem_req, mem_addr_sel, mem_wr, ir_we, mdr_we, pc_we,
                pc_sel, rf_we, halted, bus_err};
    endfunction

    task automatic set_dec(input logic [1:0] ct, input logic we, input logic mr,
                           input logic ww, input logic bw, input logic ex);
        s_ct = ct; s_we = we; s_mr = mr; s_ww = ww; s_bw = bw; s_ex = ex;
    endtask

    task automatic row(input logic rdy, input logic [13:0] e);
        row_t r;
        r.ct = s_ct; r.we = s_we; r.mr = s_mr; r.ww = s_ww; r.bw = s_bw; r.ex = s_ex;
        r.rdy = rdy; r.exp = e;
        rows.push_back(r);
    endtask

    task automatic drive(input row_t r);
        control_type = r.ct; writeenable = r.we; mem_read = r.mr;
        word_we = r.ww; byte_we = r.bw; except = r.ex; mem_ready = r.rdy;
        sb_q.push_back(r.exp);
    endtask

    // common expected vectors
    function automatic logic [13:0] v_fetch_done(); return ev(0,1,0,0,1,0,1,2'd0,0,0,0); endfunction
    function automatic logic [13:0] v_fetch_wait(); return ev(0,1,0,0,0,0,0,2'd0,0,0,0); endfunction
    function automatic logic [13:0] v_decode();     return ev(1,0,0,0,0,0,0,2'd0,0,0,0); endfunction
    function automatic logic [13:0] v_exec();       return ev(2,0,0,0,0,0,0,2'd0,0,0,0); endfunction

    task automatic test_reset(input string tag);
        logic [13:0] e;
        @(negedge clock);
        reset = 1'b1; mem_ready = 1'b0;
        control_type = 2'd0; writeenable = 1'b0; mem_read = 1'b0;
        word_we = 1'b0; byte_we = 1'b0; except = 1'b0;
        sb_q.push_back(14'd0);
        #1;
        e = sb_q.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL %s outputs in reset got=%h exp=%h", tag, obs(), e);
        end
        @(posedge clock);
        #2 reset = 1'b0;
    endtask

    task automatic test_add();
        logic [13:0] e;
        set_dec(2'd0, 1, 0, 0, 0, 0);
        row(1, v_fetch_done());
        row(1, v_decode());
        row(1, v_exec());
        row(1, ev(4,0,0,0,0,0,0,2'd0,1,0,0));
        for (int i = 0; rows.size() > 0; i++) begin
            @(negedge clock);
            drive(rows.pop_front());
            #1;
            e = sb_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL add cyc%0d got=%h exp=%h", i, obs(), e);
            end
        end
`ifdef MC_PERF_CNT_EN
        @(negedge clock);
        mem_ready = 1'b0;
        #1;
        checks++;
        if (instret !== 32'd1) begin
            errors++;
            $display("FAIL instret got=%0d exp=1", instret);
        end
`endif
    endtask

    task automatic test_branch(input logic [1:0] ct);
        logic [13:0] e;
        set_dec(ct, 0, 0, 0, 0, 0);
        row(1, v_fetch_done());
        row(1, v_decode());
        row(0, ev(2,0,0,0,0,0,1,ct,0,0,0));
        for (int i = 0; rows.size() > 0; i++) begin
            @(negedge clock);
            drive(rows.pop_front());
            #1;
            e = sb_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL branch ct%0d cyc%0d got=%h exp=%h", ct, i, obs(), e);
            end
        end
    endtask

    task automatic test_load();
        logic [13:0] e;
        set_dec(2'd0, 1, 1, 0, 0, 0);
        row(1, v_fetch_done());
        row(0, v_decode());
        row(0, v_exec());
        for (int k = 0; k < 3; k++) row(0, ev(3,1,1,0,0,0,0,2'd0,0,0,0));
        row(1, ev(3,1,1,0,0,1,0,2'd0,0,0,0));
        row(0, ev(4,0,0,0,0,0,0,2'd0,1,0,0));
        for (int i = 0; rows.size() > 0; i++) begin
            @(negedge clock);
            drive(rows.pop_front());
            #1;
            e = sb_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL load cyc%0d got=%h exp=%h", i, obs(), e);
            end
        end
    endtask

    task automatic test_store(input logic ww, input logic bw);
        logic [13:0] e;
        set_dec(2'd0, 0, 0, ww, bw, 0);
        row(1, v_fetch_done());
        row(1, v_decode());
        row(1, v_exec());
        row(0, ev(3,1,1,1,0,0,0,2'd0,0,0,0));
        row(1, ev(3,1,1,1,0,0,0,2'd0,0,0,0));
        row(1, v_fetch_done());
        set_dec(2'd0, 0, 0, 0, 0, 0);
        row(1, v_decode());
        row(1, v_exec());
        for (int i = 0; rows.size() > 0; i++) begin
            @(negedge clock);
            drive(rows.pop_front());
            #1;
            e = sb_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL store ww%0b bw%0b cyc%0d got=%h exp=%h", ww, bw, i, obs(), e);
            end
        end
    endtask

    task automatic test_timeout(input logic ready_last);
        logic [13:0] e;
        set_dec(2'd0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 15; k++) row(0, v_fetch_wait());
        if (ready_last) begin
            row(1, v_fetch_done());
            row(1, v_decode());
        end else begin
            row(0, v_fetch_wait());
            row(1, ev(5,0,0,0,0,0,0,2'd0,0,1,1));
            row(1, ev(5,0,0,0,0,0,0,2'd0,0,1,1));
        end
        for (int i = 0; rows.size() > 0; i++) begin
            @(negedge clock);
            drive(rows.pop_front());
            #1;
            e = sb_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL timeout rl%0b cyc%0d got=%h exp=%h", ready_last, i, obs(), e);
            end
        end
    endtask

    task automatic test_except();
        logic [13:0] e;
        set_dec(2'd0, 1, 0, 0, 0, 1);
        row(1, v_fetch_done());
        row(1, v_decode());
        row(1, ev(5,0,0,0,0,0,0,2'd0,0,1,0));
        row(1, ev(5,0,0,0,0,0,0,2'd0,0,1,0));
        for (int i = 0; rows.size() > 0; i++) begin
            @(negedge clock);
            drive(rows.pop_front());
            #1;
            e = sb_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL except cyc%0d got=%h exp=%h", i, obs(), e);
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [13:0] e;
        set_dec(2'd0, 1, 1, 0, 0, 0);
        row(1, v_fetch_done());
        row(0, v_decode());
        row(0, v_exec());
        row(0, ev(3,1,1,0,0,0,0,2'd0,0,0,0));
        row(0, ev(3,1,1,0,0,0,0,2'd0,0,0,0));
        for (int i = 0; rows.size() > 0; i++) begin
            @(negedge clock);
            drive(rows.pop_front());
            #1;
            e = sb_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL midmem cyc%0d got=%h exp=%h", i, obs(), e);
            end
        end
        test_reset("midmem_reset");
        set_dec(2'd0, 0, 0, 0, 0, 0);
        row(0, v_fetch_wait());
        for (int i = 0; rows.size() > 0; i++) begin
            @(negedge clock);
            drive(rows.pop_front());
            #1;
            e = sb_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL post_reset cyc%0d got=%h exp=%h", i, obs(), e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        control_type = 2'd0; writeenable = 1'b0; mem_read = 1'b0;
        word_we = 1'b0; byte_we = 1'b0; except = 1'b0; mem_ready = 1'b0;
        set_dec(2'd0, 0, 0, 0, 0, 0);
        test_reset("reset");
        test_add();
        test_branch(2'd1);
        test_branch(2'd3);
        test_load();
        test_store(1'b1, 1'b0);
        test_store(1'b0, 1'b1);
        test_reset("pre_timeout");
        test_timeout(1'b0);
        test_reset("pre_timeout_ok");
        test_timeout(1'b1);
        test_reset("pre_except");
        test_except();
        test_reset("pre_midmem");
        test_reset_mid_mem();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
